// File: rtl/rob_commit_if.sv
// Dispatch, writeback, retire and occupancy bus of the reorder buffer.
// The buffer sits on the slave side; the dispatch/FU/consumer side is the master.
interface rob_commit_if #(
    parameter int DATA_W = 16,
    parameter int AREG_W = 3
);
    logic              flush;
    logic [1:0]        alloc_req;
    logic [DATA_W-1:0] alloc_pc0;
    logic [DATA_W-1:0] alloc_pc1;
    logic [AREG_W-1:0] alloc_areg0;
    logic [AREG_W-1:0] alloc_areg1;
    logic [1:0]        alloc_ready;
    logic [2:0]        alloc_tag0;
    logic [2:0]        alloc_tag1;

    logic              wb_valid;
    logic [2:0]        wb_tag;
    logic [DATA_W-1:0] wb_value;
    logic [1:0]        wb_type;
    logic [DATA_W-1:0] wb_st_value;

    logic              cm_valid0;
    logic              cm_valid1;
    logic [1:0]        cm_type0;
    logic [1:0]        cm_type1;
    logic [AREG_W-1:0] cm_areg0;
    logic [AREG_W-1:0] cm_areg1;
    logic [DATA_W-1:0] cm_value0;
    logic [DATA_W-1:0] cm_value1;
    logic [DATA_W-1:0] cm_st0;
    logic [DATA_W-1:0] cm_st1;
    logic [DATA_W-1:0] cm_pc0;
    logic [DATA_W-1:0] cm_pc1;
    logic [3:0]        count;

    modport master (
        output flush, alloc_req, alloc_pc0, alloc_pc1, alloc_areg0, alloc_areg1,
        output wb_valid, wb_tag, wb_value, wb_type, wb_st_value,
        input  alloc_ready, alloc_tag0, alloc_tag1, count,
        input  cm_valid0, cm_valid1, cm_type0, cm_type1, cm_areg0, cm_areg1,
        input  cm_value0, cm_value1, cm_st0, cm_st1, cm_pc0, cm_pc1
    );

    modport slave (
        input  flush, alloc_req, alloc_pc0, alloc_pc1, alloc_areg0, alloc_areg1,
        input  wb_valid, wb_tag, wb_value, wb_type, wb_st_value,
        output alloc_ready, alloc_tag0, alloc_tag1, count,
        output cm_valid0, cm_valid1, cm_type0, cm_type1, cm_areg0, cm_areg1,
        output cm_value0, cm_value1, cm_st0, cm_st1, cm_pc0, cm_pc1
    );
endinterface

// File: rtl/rob_commit.sv
// 8-entry reorder buffer: dual in-order allocation, tag-addressed writeback,
// dual in-order retirement with at most one memory op per cycle.
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int AREG_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    rob_commit_if.slave rob
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    logic [DEPTH-1:0]  valid, done;
    logic [DATA_W-1:0] e_pc    [DEPTH];
    logic [AREG_W-1:0] e_areg  [DEPTH];
    logic [1:0]        e_type  [DEPTH];
    logic [DATA_W-1:0] e_value [DEPTH];
    logic [DATA_W-1:0] e_st    [DEPTH];

    logic [TAG_W-1:0] head, tail, head1, tail1;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       ready;
    logic             grant0, grant1, ret0, ret1, wb_hit;
    logic [1:0]       n_alloc, n_ret;
    logic [DEPTH-1:0] ret_mask, alloc_mask, wb_mask;

    function automatic logic is_mem(input logic [1:0] t);
        return (t == 2'b01) || (t == 2'b10);
    endfunction

    always_comb begin
        head1    = head + TAG_W'(1);
        tail1    = tail + TAG_W'(1);
        ready[0] = cnt < CNT_W'(DEPTH);
        ready[1] = cnt <= CNT_W'(DEPTH - 2);
        grant0   = rob.alloc_req[0] & ready[0];
        grant1   = rob.alloc_req[1] & ready[1] & grant0;
        n_alloc  = 2'(grant0) + 2'(grant1);

        // Retirement looks only at done bits already registered, so a result
        // can never retire on the edge that writes it back.
        ret0  = valid[head] & done[head];
        ret1  = ret0 & valid[head1] & done[head1]
              & ~(is_mem(e_type[head]) & is_mem(e_type[head1]));
        n_ret = 2'(ret0) + 2'(ret1);

        wb_hit = rob.wb_valid & valid[rob.wb_tag] & ~done[rob.wb_tag];

        ret_mask   = (DEPTH'(ret0) << head) | (DEPTH'(ret1) << head1);
        alloc_mask = (DEPTH'(grant0) << tail) | (DEPTH'(grant1) << tail1);
        wb_mask    = DEPTH'(wb_hit) << rob.wb_tag;
    end

    assign rob.alloc_ready = ready;
    assign rob.alloc_tag0  = tail;
    assign rob.alloc_tag1  = tail1;
    assign rob.count       = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= '0;
            cnt           <= '0;
            valid         <= '0;
            done          <= '0;
            rob.cm_valid0 <= 1'b0;
            rob.cm_valid1 <= 1'b0;
            rob.cm_type0  <= '0;
            rob.cm_type1  <= '0;
            rob.cm_areg0  <= '0;
            rob.cm_areg1  <= '0;
            rob.cm_value0 <= '0;
            rob.cm_value1 <= '0;
            rob.cm_st0    <= '0;
            rob.cm_st1    <= '0;
            rob.cm_pc0    <= '0;
            rob.cm_pc1    <= '0;
        end else if (rob.flush) begin
            head          <= '0;
            tail          <= '0;
            cnt           <= '0;
            valid         <= '0;
            done          <= '0;
            rob.cm_valid0 <= 1'b0;
            rob.cm_valid1 <= 1'b0;
        end else begin
            head  <= head + TAG_W'(n_ret);
            tail  <= tail + TAG_W'(n_alloc);
            cnt   <= cnt + CNT_W'(n_alloc) - CNT_W'(n_ret);
            // Retired, allocated and written-back entries are always disjoint.
            valid <= (valid & ~ret_mask) | alloc_mask;
            done  <= (done & ~ret_mask & ~alloc_mask) | wb_mask;
            rob.cm_valid0 <= ret0;
            rob.cm_valid1 <= ret1;
            if (ret0) begin
                rob.cm_type0  <= e_type[head];
                rob.cm_areg0  <= e_areg[head];
                rob.cm_value0 <= e_value[head];
                rob.cm_st0    <= e_st[head];
                rob.cm_pc0    <= e_pc[head];
            end
            if (ret1) begin
                rob.cm_type1  <= e_type[head1];
                rob.cm_areg1  <= e_areg[head1];
                rob.cm_value1 <= e_value[head1];
                rob.cm_st1    <= e_st[head1];
                rob.cm_pc1    <= e_pc[head1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant0) begin
            e_pc[tail]   <= rob.alloc_pc0;
            e_areg[tail] <= rob.alloc_areg0;
        end
        if (grant1) begin
            e_pc[tail1]   <= rob.alloc_pc1;
            e_areg[tail1] <= rob.alloc_areg1;
        end
        if (wb_hit) begin
            e_type[rob.wb_tag]  <= rob.wb_type;
            e_value[rob.wb_tag] <= rob.wb_value;
            e_st[rob.wb_tag]    <= rob.wb_st_value;
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios with literal expectations, then
// random traffic compared every cycle against a program-order queue model.
module tb_rob_commit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_commit_if #(.DATA_W(16), .AREG_W(3)) bus ();
    rob_commit #(.DEPTH(8), .DATA_W(16), .AREG_W(3)) dut (.clk(clk), .rst_n(rst_n), .rob(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0]  tag;
        logic [15:0] pc;
        logic [2:0]  areg;
        logic        done;
        logic [1:0]  t;
        logic [15:0] v;
        logic [15:0] st;
    } ent_t;

    // Model: in-flight instructions held oldest-first in a queue.
    ent_t        mq[$];
    logic [2:0]  mtail = 3'd0;
    logic [2:0]  mtail1;
    logic        m_v0 = 1'b0, m_v1 = 1'b0;
    logic [1:0]  m_t0 = '0, m_t1 = '0;
    logic [2:0]  m_a0 = '0, m_a1 = '0;
    logic [15:0] m_val0 = '0, m_val1 = '0, m_st0 = '0, m_st1 = '0, m_pc0 = '0, m_pc1 = '0;
    int          sz, nret, nal;

    function automatic logic is_mem(input logic [1:0] t);
        return (t == 2'b01) || (t == 2'b10);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mtail = 3'd0;
            m_v0 = 1'b0; m_v1 = 1'b0; m_t0 = '0; m_t1 = '0; m_a0 = '0; m_a1 = '0;
            m_val0 = '0; m_val1 = '0; m_st0 = '0; m_st1 = '0; m_pc0 = '0; m_pc1 = '0;
        end else if (bus.flush) begin
            mq.delete();
            mtail = 3'd0;
            m_v0 = 1'b0;
            m_v1 = 1'b0;
        end else begin
            sz = mq.size();
            nret = 0;
            if (sz > 0 && mq[0].done) begin
                nret = 1;
                if (sz > 1 && mq[1].done && !(is_mem(mq[0].t) && is_mem(mq[1].t))) nret = 2;
            end
            m_v0 = (nret >= 1);
            m_v1 = (nret == 2);
            if (nret >= 1) begin
                m_t0 = mq[0].t; m_a0 = mq[0].areg; m_val0 = mq[0].v; m_st0 = mq[0].st; m_pc0 = mq[0].pc;
            end
            if (nret == 2) begin
                m_t1 = mq[1].t; m_a1 = mq[1].areg; m_val1 = mq[1].v; m_st1 = mq[1].st; m_pc1 = mq[1].pc;
            end
            if (bus.wb_valid) begin
                foreach (mq[i]) begin
                    if (mq[i].tag == bus.wb_tag && !mq[i].done) begin
                        mq[i].done = 1'b1;
                        mq[i].t = bus.wb_type;
                        mq[i].v = bus.wb_value;
                        mq[i].st = bus.wb_st_value;
                    end
                end
            end
            repeat (nret) void'(mq.pop_front());
            nal = 0;
            if (bus.alloc_req[0] && sz < 8) begin
                nal = 1;
                if (bus.alloc_req[1] && sz < 7) nal = 2;
            end
            if (nal >= 1)
                mq.push_back('{tag: mtail, pc: bus.alloc_pc0, areg: bus.alloc_areg0,
                               done: 1'b0, t: 2'b00, v: 16'h0, st: 16'h0});
            if (nal == 2)
                mq.push_back('{tag: mtail + 3'd1, pc: bus.alloc_pc1, areg: bus.alloc_areg1,
                               done: 1'b0, t: 2'b00, v: 16'h0, st: 16'h0});
            mtail = mtail + 3'(nal);
        end
    end

    always @(negedge clk) begin
        mtail1 = mtail + 3'd1;
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("alloc_ready", 32'(bus.alloc_ready), {30'b0, mq.size() <= 6, mq.size() <= 7});
        chk("alloc_tag0", 32'(bus.alloc_tag0), 32'(mtail));
        chk("alloc_tag1", 32'(bus.alloc_tag1), 32'(mtail1));
        chk("cm_valid0", 32'(bus.cm_valid0), 32'(m_v0));
        chk("cm_valid1", 32'(bus.cm_valid1), 32'(m_v1));
        chk("cm_type0", 32'(bus.cm_type0), 32'(m_t0));
        chk("cm_type1", 32'(bus.cm_type1), 32'(m_t1));
        chk("cm_areg0", 32'(bus.cm_areg0), 32'(m_a0));
        chk("cm_areg1", 32'(bus.cm_areg1), 32'(m_a1));
        chk("cm_value0", 32'(bus.cm_value0), 32'(m_val0));
        chk("cm_value1", 32'(bus.cm_value1), 32'(m_val1));
        chk("cm_st0", 32'(bus.cm_st0), 32'(m_st0));
        chk("cm_st1", 32'(bus.cm_st1), 32'(m_st1));
        chk("cm_pc0", 32'(bus.cm_pc0), 32'(m_pc0));
        chk("cm_pc1", 32'(bus.cm_pc1), 32'(m_pc1));
    end

    task automatic idle();
        bus.flush = 1'b0;
        bus.alloc_req = 2'b00;
        bus.alloc_pc0 = '0;
        bus.alloc_pc1 = '0;
        bus.alloc_areg0 = '0;
        bus.alloc_areg1 = '0;
        bus.wb_valid = 1'b0;
        bus.wb_tag = '0;
        bus.wb_value = '0;
        bus.wb_type = '0;
        bus.wb_st_value = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic alloc(input logic [1:0] req, input logic [15:0] p0, input logic [15:0] p1);
        idle();
        bus.alloc_req = req;
        bus.alloc_pc0 = p0;
        bus.alloc_pc1 = p1;
        bus.alloc_areg0 = p0[3:1];
        bus.alloc_areg1 = p1[3:1];
    endtask

    task automatic wb(input logic [2:0] tag, input logic [1:0] t, input logic [15:0] v, input logic [15:0] s);
        idle();
        bus.wb_valid = 1'b1;
        bus.wb_tag = tag;
        bus.wb_type = t;
        bus.wb_value = v;
        bus.wb_st_value = s;
    endtask

    initial begin
        idle();
        #12 rst_n = 1'b1;
        tick();
        chk("reset_count", 32'(bus.count), 0);
        chk("reset_cm_valid0", 32'(bus.cm_valid0), 0);

        // Dual allocation from reset, then out-of-order writeback, in-order retire.
        alloc(2'b11, 16'h0010, 16'h0012);
        #1;
        chk("first_tag0", 32'(bus.alloc_tag0), 0);
        chk("first_tag1", 32'(bus.alloc_tag1), 1);
        tick();
        chk("alloc2_count", 32'(bus.count), 2);
        chk("alloc2_cm_valid1", 32'(bus.cm_valid1), 0);
        wb(3'd1, 2'b00, 16'h00AA, 16'h0);
        tick();
        chk("wb1_no_retire", 32'(bus.cm_valid0), 0);
        wb(3'd0, 2'b00, 16'h0055, 16'h0);
        tick();
        chk("wb_edge_no_retire", 32'(bus.cm_valid0), 0);
        idle();
        tick();
        chk("dual_valid0", 32'(bus.cm_valid0), 1);
        chk("dual_valid1", 32'(bus.cm_valid1), 1);
        chk("dual_value0", 32'(bus.cm_value0), 32'h0055);
        chk("dual_value1", 32'(bus.cm_value1), 32'h00AA);
        chk("dual_pc0", 32'(bus.cm_pc0), 32'h0010);
        chk("dual_count", 32'(bus.count), 0);

        // Fill to capacity from a clean pointer state.
        idle();
        bus.flush = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            alloc(2'b11, 16'(16'h0100 + 4 * i), 16'(16'h0102 + 4 * i));
            tick();
        end
        idle();
        chk("full_count", 32'(bus.count), 8);
        chk("full_ready", 32'(bus.alloc_ready), 0);
        alloc(2'b11, 16'h0F00, 16'h0F02);
        tick();
        chk("full_ignored_count", 32'(bus.count), 8);
        chk("full_tail_wrapped", 32'(bus.alloc_tag0), 0);
        wb(3'd1, 2'b10, 16'h0200, 16'h0);
        tick();
        wb(3'd0, 2'b01, 16'h0100, 16'hBEEF);
        tick();
        idle();
        tick();
        chk("mem_pair_valid0", 32'(bus.cm_valid0), 1);
        chk("mem_pair_valid1", 32'(bus.cm_valid1), 0);
        chk("mem_pair_type0", 32'(bus.cm_type0), 1);
        chk("mem_pair_st0", 32'(bus.cm_st0), 32'hBEEF);
        chk("mem_pair_addr0", 32'(bus.cm_value0), 32'h0100);
        chk("freed_ready", 32'(bus.alloc_ready), 1);
        chk("freed_count", 32'(bus.count), 7);
        tick();
        chk("load_valid0", 32'(bus.cm_valid0), 1);
        chk("load_type0", 32'(bus.cm_type0), 2);
        chk("load_addr0", 32'(bus.cm_value0), 32'h0200);
        chk("load_valid1", 32'(bus.cm_valid1), 0);
        chk("load_count", 32'(bus.count), 6);

        // Ignored writebacks, then flush against pending alloc/wb/retire.
        bus.flush = 1'b1;
        tick();
        alloc(2'b11, 16'h0020, 16'h0022);
        tick();
        alloc(2'b11, 16'h0024, 16'h0026);
        tick();
        alloc(2'b01, 16'h0028, 16'h0);
        tick();
        wb(3'd5, 2'b00, 16'h1234, 16'h0);
        tick();
        chk("wb_unalloc_count", 32'(bus.count), 5);
        chk("wb_unalloc_noretire", 32'(bus.cm_valid0), 0);
        wb(3'd0, 2'b00, 16'h0001, 16'h0);
        tick();
        wb(3'd0, 2'b00, 16'h0002, 16'h0);
        tick();
        chk("dup_wb_valid0", 32'(bus.cm_valid0), 1);
        chk("dup_wb_value0", 32'(bus.cm_value0), 32'h0001);
        chk("dup_wb_count", 32'(bus.count), 4);
        idle();
        tick();
        chk("idle_valid0", 32'(bus.cm_valid0), 0);
        chk("idle_hold_value0", 32'(bus.cm_value0), 32'h0001);
        alloc(2'b01, 16'h002A, 16'h0);
        tick();
        wb(3'd1, 2'b00, 16'h0077, 16'h0);
        tick();
        chk("preflush_count", 32'(bus.count), 5);
        alloc(2'b11, 16'h0030, 16'h0032);
        bus.flush = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_tag = 3'd2;
        bus.wb_value = 16'h0099;
        tick();
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_tail", 32'(bus.alloc_tag0), 0);
        chk("flush_valid0", 32'(bus.cm_valid0), 0);

        // Asynchronous reset in the middle of a cycle with retirement under way.
        alloc(2'b11, 16'h0040, 16'h0042);
        tick();
        wb(3'd0, 2'b00, 16'h0011, 16'h0);
        tick();
        wb(3'd1, 2'b00, 16'h0022, 16'h0);
        tick();
        alloc(2'b11, 16'h0044, 16'h0046);
        tick();
        chk("prereset_valid0", 32'(bus.cm_valid0), 1);
        chk("prereset_value0", 32'(bus.cm_value0), 32'h0022);
        chk("prereset_count", 32'(bus.count), 2);
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk("async_count", 32'(bus.count), 0);
        chk("async_valid0", 32'(bus.cm_valid0), 0);
        chk("async_value0", 32'(bus.cm_value0), 0);
        chk("async_tag0", 32'(bus.alloc_tag0), 0);
        rst_n = 1'b1;
        tick();

        // Random traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            idle();
            bus.flush = ($urandom_range(0, 63) == 0);
            bus.alloc_req = 2'($urandom_range(0, 3));
            bus.alloc_pc0 = 16'($urandom);
            bus.alloc_pc1 = 16'($urandom);
            bus.alloc_areg0 = 3'($urandom);
            bus.alloc_areg1 = 3'($urandom);
            bus.wb_valid = ($urandom_range(0, 3) != 0);
            bus.wb_tag = 3'($urandom);
            bus.wb_type = 2'($urandom_range(0, 2));
            bus.wb_value = 16'($urandom);
            bus.wb_st_value = 16'($urandom);
            if (i == 1500) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- 8-entry reorder buffer sitting directly downstream of the functional unit.
- Allocates tags in program order for the dual-issue dispatch stage (up to 2 per cycle).
- Captures FU broadcast results by destination tag.
- Retires up to 2 completed instructions per cycle, in order, to the register file and memory stage.

Parameters:
- DEPTH, 8, number of entries; fixed to match the 3-bit tag.
- DATA_W, 16, width of result, PC and store data.
- AREG_W, 3, architectural destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all entries
- alloc_req  in  2  dispatch requests; bit1 honoured only with bit0
- alloc_pc0, alloc_pc1  in  16  PC of each dispatched instruction
- alloc_areg0, alloc_areg1  in  3  architectural destination register
- alloc_ready  out  2  bit0 = at least 1 free entry; bit1 = at least 2 free entries
- alloc_tag0, alloc_tag1  out  3  combinational: tail, tail+1 (mod 8)
- wb_valid  in  1  FU broadcast strobe
- wb_tag  in  3  FU dest tag
- wb_value  in  16  FU sum (ALU result or memory address)
- wb_type  in  2  00 ALU, 01 STORE, 10 LOAD
- wb_st_value  in  16  FU store data
- cm_valid0, cm_valid1  out  1  retire strobes; slot0 is older
- cm_type0, cm_type1  out  2  type of retired entry
- cm_areg0, cm_areg1  out  3  destination register
- cm_value0, cm_value1  out  16  result or address
- cm_st0, cm_st1  out  16  store data
- cm_pc0, cm_pc1  out  16  retired PC
- count  out  4  occupied entries, 0..8

Behaviour:
- Reset (rst_n low, async): head=0, tail=0, count=0, all valid/done bits 0, all cm_* outputs 0. Entry payload is don't-care.
- Entry fields: valid, done, pc, areg, type, value, st.
- Allocation at posedge:
  - Granted = alloc_req masked by alloc_ready, with bit1 dropped if bit0 is not granted.
  - Slot0 goes to tail; slot1 goes to tail+1.
  - Each allocated entry gets valid=1, done=0, pc/areg captured.
  - Tail advances by the number granted, wrapping mod 8.
- alloc_ready is computed from the current count only. Entries freed by this cycle's commit are not visible until the next cycle.
- Writeback at posedge, when wb_valid=1 and entry[wb_tag] is valid and not done:
  - Entry captures value, type, st and sets done=1.
  - Writeback to an invalid or already-done entry is ignored.
- Commit:
  - Registered outputs, 1-cycle latency: cm_* reflect entries retired at the previous edge.
  - Slot0 retires head if valid & done.
  - Slot1 retires head+1 only if slot0 retires and head+1 is valid & done.
  - Slot1 is blocked if both retiring entries are memory ops (type 01 or 10). At most 1 memory op retires per cycle.
  - Retired entries have valid and done cleared. Head advances by the number retired.
  - cm_valid* deassert in any cycle with no retirement; other cm_* fields hold.
- count_next = count + allocated − retired. Allocate and retire in the same cycle is legal at any occupancy. At count=8, alloc_ready=00 and the FU still writes back.
- Latency: writeback-to-commit is minimum 1 edge (done set) plus 1 edge (cm_* registered). An instruction cannot retire on the edge it is written back.
- Flush (priority over alloc/wb/commit at that edge): clears all valid and done; sets head=tail=count=0 and cm_valid*=0.
- rst_n asserted mid-operation aborts everything immediately, regardless of clk.

Test Plan:
- Reset, then alloc_req=11 with pc 0x0010/0x0012 → alloc_tag0=0, alloc_tag1=1; count=2 after the edge; cm_valid*=0.
- Writeback tag1 (ALU, 0x00AA) then tag0 (ALU, 0x0055) on consecutive cycles:
  - Nothing retires after tag1 alone.
  - One cycle after tag0's edge, cm_valid0=cm_valid1=1 with values 0x0055 and 0x00AA, in order.
  - count returns to 0.
- Fill to 8 with 4 dual allocations → alloc_ready=00. Extra alloc_req=11 is ignored and tail stays 0 (wrapped). Retiring head frees a slot: alloc_ready=01 on the following cycle.
- Entries 0 (STORE, addr 0x0100, st 0xBEEF) and 1 (LOAD, addr 0x0200) both done → only slot0 retires (cm_type0=01, cm_st0=0xBEEF). The load retires alone next cycle.
- Writeback to an unallocated tag 5 and a duplicate writeback to a done tag → no state change; count unchanged.
- Flush with 5 entries in flight plus a simultaneous alloc and wb → count=0, head=tail=0, cm_valid*=0 the next cycle.
- Async rst_n pulse mid-cycle → immediate clear of the same state.
